// File: rtl/arb_pkg.sv
// Shared types, sizes and the round-robin search helper for rr_arbiter8.
package arb_pkg;

   localparam int unsigned NUM_REQ = 8;
   localparam int unsigned IDX_W   = 3;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   // Result of a round-robin search: whether any request was found and which one
   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } pick_t;

   // First set request searching upward from ptr, wrapping 7 -> 0
   function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                     input logic [IDX_W-1:0]   ptr);
      pick_t            res;
      logic [IDX_W-1:0] cand;
      res = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = ptr + IDX_W'(i);
         if (!res.valid && req[cand]) begin
            res.valid = 1'b1;
            res.idx   = cand;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/encoder83.sv
// 8-to-3 binary encoder for a one-hot or all-zero input; all-zero encodes as 0.
module encoder83
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] in_i,
   output logic [IDX_W-1:0]   out_o
);

   // OR together the indices of set bits; exact for one-hot inputs
   always_comb begin
      out_o = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (in_i[i]) begin
            out_o = out_o | IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-requester round-robin arbiter with a one-cycle dead time
// between grants. Define RR_ARBITER8_TIMEOUT_EN to add a hold limit of
// MAX_HOLD cycles per grant, reported by a one-cycle timeout pulse.
module rr_arbiter8
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               done,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grantIdx,
   output logic               grantValid,
   output logic               timeout
);

   arb_state_t         state_q;
   logic [IDX_W-1:0]   ptr_q;
   logic [IDX_W-1:0]   ptr_d;
   logic [NUM_REQ-1:0] grant_q;
   pick_t              pick_c;
   logic               release_c;
   logic               expire_c;

   // Reject out-of-range hold limits at elaboration
   if ((MAX_HOLD < 2) || (MAX_HOLD > 256)) begin : g_bad_max_hold
      $error("rr_arbiter8: MAX_HOLD must be within 2..256");
   end

   // Candidate winner, release condition and post-release pointer
   always_comb begin
      pick_c    = rr_pick(req, ptr_q);
      release_c = done | ~req[grantIdx];
      ptr_d     = grantIdx + IDX_W'(1);
   end

`ifdef RR_ARBITER8_TIMEOUT_EN
   localparam int unsigned CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   logic [CNT_W-1:0] hold_cnt_q;
   logic             timeout_q;

   assign expire_c = (hold_cnt_q == HOLD_LAST);

   // Hold counter restarts at every grant; timeout pulses for the first IDLE cycle after a forced release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         if (state_q == IDLE) begin
            hold_cnt_q <= '0;
         end else begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
         end
         timeout_q <= (state_q == BUSY) && !release_c && expire_c;
      end
   end

   assign timeout = timeout_q;
`else
   assign expire_c = 1'b0;
   assign timeout  = 1'b0;
`endif

   // Arbitration FSM: grant from IDLE, release from BUSY, always passing through IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_c.valid) begin
                  state_q <= BUSY;
                  grant_q <= NUM_REQ'(1) << pick_c.idx;
               end
            end
            BUSY: begin
               if (release_c || expire_c) begin
                  state_q <= IDLE;
                  grant_q <= '0;
                  ptr_q   <= ptr_d;
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= '0;
            end
         endcase
      end
   end

   // Index and valid follow the registered grant with no added latency
   encoder83 u_enc (
      .in_i  (grant_q),
      .out_o (grantIdx)
   );

   assign grant      = grant_q;
   assign grantValid = |grant_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8; adapts the hold test to RR_ARBITER8_TIMEOUT_EN.
module tb_rr_arbiter8;

   localparam int unsigned MAX_HOLD = 4;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] req   = 8'h00;
   logic       done  = 1'b0;
   logic [7:0] grant;
   logic [2:0] grantIdx;
   logic       grantValid;
   logic       timeout;

   always #5 clk = ~clk;

   rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .done       (done),
      .grant      (grant),
      .grantIdx   (grantIdx),
      .grantValid (grantValid),
      .timeout    (timeout)
   );

   typedef struct {
      logic [7:0] grant;
      logic       timeout;
      string      name;
   } exp_t;

   typedef struct {
      logic [7:0] req;
      logic       done;
      logic [7:0] grant;
   } vec_t;

   exp_t        exp_q[$];
   vec_t        tbl[$];
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   function automatic logic [2:0] idx_of(input logic [7:0] g);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (g[i]) r = 3'(i);
      end
      return r;
   endfunction

   // Pop the oldest expectation and compare against the live outputs
   task automatic check_out();
      exp_t e;
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: output observed with no expectation queued");
         return;
      end
      e = exp_q.pop_front();
      if (grant !== e.grant || grantIdx !== idx_of(e.grant) ||
          grantValid !== (e.grant != 8'h00) || timeout !== e.timeout) begin
         n_fail++;
         $display("FAIL %s: got grant=%h idx=%0d valid=%b timeout=%b, want grant=%h idx=%0d valid=%b timeout=%b",
                  e.name, grant, grantIdx, grantValid, timeout,
                  e.grant, idx_of(e.grant), (e.grant != 8'h00), e.timeout);
      end
   endtask

   // Drive one cycle of inputs from a falling edge, check just after the rising edge
   task automatic run_step(input logic [7:0] r, input logic d,
                           input logic [7:0] eg, input logic et, input string name);
      exp_t e;
      req  = r;
      done = d;
      e.grant   = eg;
      e.timeout = et;
      e.name    = name;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check_out();
      @(negedge clk);
   endtask

   task automatic do_reset();
      exp_t e;
      req   = 8'h00;
      done  = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      e.grant   = 8'h00;
      e.timeout = 1'b0;
      e.name    = "in_reset";
      exp_q.push_back(e);
      check_out();
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] eg;
      logic       et;
      exp_t       e;

      // req, done, expected grant after the edge
      tbl.push_back('{8'h05, 1'b0, 8'h01});
      tbl.push_back('{8'h05, 1'b1, 8'h00});
      tbl.push_back('{8'h05, 1'b0, 8'h04});
      tbl.push_back('{8'h05, 1'b1, 8'h00});
      tbl.push_back('{8'h05, 1'b0, 8'h01});
      tbl.push_back('{8'h05, 1'b0, 8'h01});
      tbl.push_back('{8'h05, 1'b1, 8'h00});
      tbl.push_back('{8'h04, 1'b0, 8'h04});
      tbl.push_back('{8'hFF, 1'b0, 8'h04});
      tbl.push_back('{8'hFF, 1'b1, 8'h00});
      tbl.push_back('{8'hFF, 1'b0, 8'h08});
      tbl.push_back('{8'h00, 1'b1, 8'h00});
      tbl.push_back('{8'h00, 1'b0, 8'h00});
      tbl.push_back('{8'h02, 1'b0, 8'h02});
      tbl.push_back('{8'h00, 1'b0, 8'h00});
      tbl.push_back('{8'h06, 1'b0, 8'h04});
      tbl.push_back('{8'h00, 1'b1, 8'h00});
      tbl.push_back('{8'h40, 1'b0, 8'h40});
      tbl.push_back('{8'h40, 1'b1, 8'h00});
      tbl.push_back('{8'h81, 1'b0, 8'h80});
      tbl.push_back('{8'h81, 1'b1, 8'h00});
      tbl.push_back('{8'h81, 1'b0, 8'h01});
      tbl.push_back('{8'h00, 1'b0, 8'h00});
      tbl.push_back('{8'h00, 1'b1, 8'h00});
      tbl.push_back('{8'h01, 1'b1, 8'h01});
      tbl.push_back('{8'h01, 1'b1, 8'h00});

      do_reset();

      for (int k = 0; k < 20; k++) begin
         run_step(8'h00, 1'b0, 8'h00, 1'b0, $sformatf("idle[%0d]", k));
      end

      foreach (tbl[i]) begin
         run_step(tbl[i].req, tbl[i].done, tbl[i].grant, 1'b0, $sformatf("tbl[%0d]", i));
      end

      // Long hold with done low: forced release every MAX_HOLD cycles only with the timeout feature
      do_reset();
      for (int k = 1; k <= 12; k++) begin
`ifdef RR_ARBITER8_TIMEOUT_EN
         if (k % 5 == 0) begin
            eg = 8'h00;
            et = 1'b1;
         end else begin
            eg = 8'h10;
            et = 1'b0;
         end
`else
         eg = 8'h10;
         et = 1'b0;
`endif
         run_step(8'h10, 1'b0, eg, et, $sformatf("hold[%0d]", k));
      end
      run_step(8'h00, 1'b1, 8'h00, 1'b0, "hold_end");

      // Asynchronous reset in the middle of a grant, then arbitration restarts at ptr 0
      do_reset();
      run_step(8'h08, 1'b0, 8'h08, 1'b0, "pre_rst_grant");
      run_step(8'h08, 1'b1, 8'h00, 1'b0, "pre_rst_release");
      run_step(8'h08, 1'b0, 8'h08, 1'b0, "pre_rst_regrant");
      #2;
      rst_n = 1'b0;
      #1;
      e.grant   = 8'h00;
      e.timeout = 1'b0;
      e.name    = "rst_mid_cycle";
      exp_q.push_back(e);
      check_out();
      @(negedge clk);
      rst_n = 1'b1;
      run_step(8'h22, 1'b0, 8'h02, 1'b0, "post_rst_ptr0");
      run_step(8'h00, 1'b1, 8'h00, 1'b0, "post_rst_release");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
